// File: rtl/jt12_pg_mux.sv
// Time-multiplexed FM phase generator: per-slot phase accumulators fed by a
// four-stage increment pipeline (fnum/PM -> block shift/clamp -> detune/mul -> accumulate).
module jt12_pg_mux #(
    parameter int SLOTS = 24,
    parameter int PHW   = 20,
    parameter int OUTW  = 10,
    parameter int PMW   = 8,
    parameter int DTW   = 6,
    parameter int CLAMP = 69905
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [10:0]              fnum_i,
    input  logic [2:0]               block_i,
    input  logic [3:0]               mul_i,
    input  logic [DTW-1:0]           dt_i,
    input  logic [PMW-1:0]           pm_i,
    input  logic                     pg_rst_i,
    input  logic                     pg_stop_i,
    output logic [$clog2(SLOTS)-1:0] slot_o,
    output logic                     zero_o,
    output logic                     valid_o,
    output logic [4:0]               keycode_o,
    output logic [OUTW-1:0]          phase_o
);
    localparam int SW = $clog2(SLOTS);

    logic [SW-1:0]   r_s;

    logic [PHW-1:0]  r1_f;
    logic [2:0]      r1_blk;
    logic [4:0]      r1_kc;
    logic [3:0]      r1_mul;
    logic [DTW-1:0]  r1_dt;
    logic            r1_rst;
    logic            r1_stop;
    logic [SW-1:0]   r1_slot;

    logic [PHW-1:0]  r2_inc;
    logic [4:0]      r2_kc;
    logic [3:0]      r2_mul;
    logic [DTW-1:0]  r2_dt;
    logic            r2_rst;
    logic            r2_stop;
    logic [SW-1:0]   r2_slot;

    logic [PHW-1:0]  r3_inc;
    logic [4:0]      r3_kc;
    logic            r3_rst;
    logic            r3_stop;
    logic [SW-1:0]   r3_slot;

    logic [3:0]      r_vld;
    logic            r_zero;
    logic [SW-1:0]   r_slot_o;
    logic [4:0]      r_kc_o;
    logic [OUTW-1:0] r_phase_o;
    logic [PHW-1:0]  r_store [SLOTS];

    logic [PHW-1:0]  w_f_sum;
    logic [PHW-1:0]  w_f;
    logic [4:0]      w_kc;
    logic [PHW+6:0]  w_shl;
    logic [PHW+4:0]  w_inc_raw;
    logic [PHW-1:0]  w_inc2;
    logic [PHW+1:0]  w_dt_sum;
    logic [PHW:0]    w_dt_pos;
    logic [PHW+4:0]  w_mult;
    logic [PHW-1:0]  w_inc3;
    logic [PHW-1:0]  w_acc;
    logic [PHW-1:0]  w_next;
    logic [SW-1:0]   w_s_next;

    // Stage 1: PM-adjusted doubled fnum (floored at zero) and keycode.
    always_comb begin
        w_f_sum = {{(PHW-12){1'b0}}, fnum_i, 1'b0} + {{(PHW-PMW){pm_i[PMW-1]}}, pm_i};
        if (w_f_sum[PHW-1]) begin
            w_f = {PHW{1'b0}};
        end else begin
            w_f = w_f_sum;
        end
        w_kc = {block_i, fnum_i[10], fnum_i[10] ? (|fnum_i[9:7]) : (&fnum_i[9:7])};
    end

    // Stage 2: octave shift then optional ceiling; compare before truncating to PHW.
    always_comb begin
        w_shl     = {7'b0000000, r1_f} << r1_blk;
        w_inc_raw = w_shl[PHW+6:2];
        if ((CLAMP != 0) && (w_inc_raw > (PHW+5)'(CLAMP))) begin
            w_inc2 = PHW'(CLAMP);
        end else begin
            w_inc2 = w_inc_raw[PHW-1:0];
        end
    end

    // Stage 3: detune with a zero floor, then multiplier (0 selects x0.5).
    always_comb begin
        w_dt_sum = {2'b00, r2_inc} + {{(PHW+2-DTW){r2_dt[DTW-1]}}, r2_dt};
        if (w_dt_sum[PHW+1]) begin
            w_dt_pos = {(PHW+1){1'b0}};
        end else begin
            w_dt_pos = w_dt_sum[PHW:0];
        end
        w_mult = {4'b0000, w_dt_pos} * {{(PHW+1){1'b0}}, r2_mul};
        if (r2_mul != 4'd0) begin
            w_inc3 = w_mult[PHW-1:0];
        end else begin
            w_inc3 = w_dt_pos[PHW:1];
        end
    end

    // Stage 4: accumulate against the slot's stored phase; key-on reset beats stop.
    always_comb begin
        w_acc = r_store[r3_slot];
        if (r3_rst) begin
            w_next = {PHW{1'b0}};
        end else if (r3_stop) begin
            w_next = w_acc;
        end else begin
            w_next = w_acc + r3_inc;
        end
        if (r_s == SW'(SLOTS-1)) begin
            w_s_next = {SW{1'b0}};
        end else begin
            w_s_next = r_s + SW'(1);
        end
    end

    // Slot counter, pipeline registers, phase store and outputs, all gated by clk_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s       <= {SW{1'b0}};
            r1_f      <= {PHW{1'b0}};
            r1_blk    <= 3'd0;
            r1_kc     <= 5'd0;
            r1_mul    <= 4'd0;
            r1_dt     <= {DTW{1'b0}};
            r1_rst    <= 1'b0;
            r1_stop   <= 1'b0;
            r1_slot   <= {SW{1'b0}};
            r2_inc    <= {PHW{1'b0}};
            r2_kc     <= 5'd0;
            r2_mul    <= 4'd0;
            r2_dt     <= {DTW{1'b0}};
            r2_rst    <= 1'b0;
            r2_stop   <= 1'b0;
            r2_slot   <= {SW{1'b0}};
            r3_inc    <= {PHW{1'b0}};
            r3_kc     <= 5'd0;
            r3_rst    <= 1'b0;
            r3_stop   <= 1'b0;
            r3_slot   <= {SW{1'b0}};
            r_vld     <= 4'd0;
            r_zero    <= 1'b0;
            r_slot_o  <= {SW{1'b0}};
            r_kc_o    <= 5'd0;
            r_phase_o <= {OUTW{1'b0}};
            for (int i = 0; i < SLOTS; i++) begin
                r_store[i] <= {PHW{1'b0}};
            end
        end else if (clk_en) begin
            r_s     <= w_s_next;
            r1_f    <= w_f;
            r1_blk  <= block_i;
            r1_kc   <= w_kc;
            r1_mul  <= mul_i;
            r1_dt   <= dt_i;
            r1_rst  <= pg_rst_i;
            r1_stop <= pg_stop_i;
            r1_slot <= r_s;
            r2_inc  <= w_inc2;
            r2_kc   <= r1_kc;
            r2_mul  <= r1_mul;
            r2_dt   <= r1_dt;
            r2_rst  <= r1_rst;
            r2_stop <= r1_stop;
            r2_slot <= r1_slot;
            r3_inc  <= w_inc3;
            r3_kc   <= r2_kc;
            r3_rst  <= r2_rst;
            r3_stop <= r2_stop;
            r3_slot <= r2_slot;
            r_vld   <= {r_vld[2:0], 1'b1};
            r_zero  <= r_vld[2] && (r3_slot == {SW{1'b0}});
            r_slot_o  <= r3_slot;
            r_kc_o    <= r3_kc;
            r_phase_o <= w_next[PHW-1 -: OUTW];
            r_store[r3_slot] <= w_next;
        end else begin
            r_s <= r_s;
        end
    end

    assign slot_o    = r_slot_o;
    assign zero_o    = r_zero;
    assign valid_o   = r_vld[3];
    assign keycode_o = r_kc_o;
    assign phase_o   = r_phase_o;
endmodule

// File: tb/tb_jt12_pg_mux.sv
// Directed bench for jt12_pg_mux: a clamping and a non-clamping instance share stimulus.
module tb_jt12_pg_mux;
    localparam int SLOTS = 24;

    typedef struct {
        logic [10:0] fnum;
        logic [2:0]  blk;
        logic [3:0]  mul;
        logic [5:0]  dt;
        logic [7:0]  pm;
        int          revs;
        int          exp_a;
        int          exp_b;
        int          exp_kc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_en = 1'b0;
    logic [10:0] fnum = 11'd0;
    logic [2:0]  blk = 3'd0;
    logic [3:0]  mul = 4'd0;
    logic [5:0]  dt = 6'd0;
    logic [7:0]  pm = 8'd0;
    logic        prst = 1'b0;
    logic        stop = 1'b0;

    logic [4:0] slot_a, slot_b, kc_a, kc_b;
    logic       zero_a, zero_b, valid_a, valid_b;
    logic [9:0] phase_a, phase_b;

    int n_chk = 0;
    int n_fail = 0;
    int en_cnt = 0;
    vec_t tab [10];

    always #5 clk = ~clk;

    jt12_pg_mux u_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .fnum_i(fnum), .block_i(blk),
        .mul_i(mul), .dt_i(dt), .pm_i(pm), .pg_rst_i(prst), .pg_stop_i(stop),
        .slot_o(slot_a), .zero_o(zero_a), .valid_o(valid_a), .keycode_o(kc_a), .phase_o(phase_a)
    );

    jt12_pg_mux #(.CLAMP(0)) u_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .fnum_i(fnum), .block_i(blk),
        .mul_i(mul), .dt_i(dt), .pm_i(pm), .pg_rst_i(prst), .pg_stop_i(stop),
        .slot_o(slot_b), .zero_o(zero_b), .valid_o(valid_b), .keycode_o(kc_b), .phase_o(phase_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at enable %0d: got %0d, expected %0d", nm, en_cnt, act, exp);
        end
    endtask

    function automatic int pack_a();
        return int'({slot_a, zero_a, valid_a, kc_a, phase_a});
    endfunction

    function automatic int pack_b();
        return int'({slot_b, zero_b, valid_b, kc_b, phase_b});
    endfunction

    task automatic chk_ctl();
        int ev, es;
        ev = (en_cnt >= 4) ? 1 : 0;
        es = (en_cnt >= 4) ? (en_cnt - 4) % SLOTS : 0;
        chk("valid_a", int'(valid_a), ev);
        chk("slot_a", int'(slot_a), es);
        chk("zero_a", int'(zero_a), (ev == 1 && es == 0) ? 1 : 0);
        chk("valid_b", int'(valid_b), ev);
        chk("slot_b", int'(slot_b), es);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clk_en = 1'b0;
        #2;
        chk("reset_outs_a", pack_a(), 0);
        chk("reset_outs_b", pack_b(), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        en_cnt = 0;
    endtask

    // One enabled cycle; every 7th enable is followed by an idle cycle.
    task automatic do_enable();
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        en_cnt++;
        chk_ctl();
        if (en_cnt % 7 == 0) begin
            clk_en = 1'b0;
            @(posedge clk);
            #1;
            chk_ctl();
        end
    endtask

    task automatic set_in(input vec_t v);
        fnum = v.fnum; blk = v.blk; mul = v.mul; dt = v.dt; pm = v.pm;
        prst = 1'b0; stop = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx, input bit rst_first);
        int total, lo;
        if (rst_first) do_reset();
        set_in(v);
        total = v.revs * SLOTS + 3;
        lo = (v.revs - 1) * SLOTS + 4;
        for (int e = 0; e < total; e++) begin
            do_enable();
            if (en_cnt >= lo) begin
                chk($sformatf("phase_a[%0d]", idx), int'(phase_a), v.exp_a);
                chk($sformatf("phase_b[%0d]", idx), int'(phase_b), v.exp_b);
                chk($sformatf("keycode[%0d]", idx), int'(kc_a), v.exp_kc);
            end
        end
        clk_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int i_in, s_in, r_in, ex;
        tab[0] = '{11'h200, 3'd4, 4'd1,  6'd0,    8'd0,    3, 12,   12,  16};
        tab[1] = '{11'h200, 3'd4, 4'd0,  6'd0,    8'd0,    3, 6,    6,   16};
        tab[2] = '{11'h200, 3'd4, 4'd15, 6'd0,    8'd0,    3, 180,  180, 16};
        tab[3] = '{11'h7FF, 3'd7, 4'd1,  6'd0,    8'd0,    1, 68,   127, 31};
        tab[4] = '{11'h7FF, 3'd7, 4'd1,  6'd0,    8'd0,    2, 136,  255, 31};
        tab[5] = '{11'h010, 3'd4, 4'd1,  6'd0,    8'h80,   2, 0,    0,   16};
        tab[6] = '{11'h014, 3'd0, 4'd1,  6'h20,   8'd0,    2, 0,    0,   0};
        tab[7] = '{11'h200, 3'd4, 4'd15, 6'h1F,   8'd0,    3, 181,  181, 16};
        tab[8] = '{11'h200, 3'd4, 4'd1,  6'd0,    8'h64,   3, 13,   13,  16};
        tab[9] = '{11'h7FF, 3'd7, 4'd15, 6'd0,    8'd0,    2, 1023, 766, 31};

        #1;
        for (int i = 0; i < 10; i++) begin
            run_vec(tab[i], i, 1'b1);
        end

        // Slot 5: normal for 2 revs, stopped for revs 3-5, reset+stop on rev 6, normal on rev 7.
        do_reset();
        set_in(tab[0]);
        for (int e = 0; e < 7 * SLOTS + 3; e++) begin
            i_in = en_cnt + 1;
            s_in = (i_in - 1) % SLOTS;
            r_in = (i_in - 1) / SLOTS + 1;
            stop = (s_in == 5 && r_in >= 3 && r_in <= 7 - 1) && (i_in <= 7 * SLOTS);
            prst = (s_in == 5 && r_in == 6);
            do_enable();
            if (en_cnt >= 4) begin
                i_in = en_cnt - 3;
                s_in = (i_in - 1) % SLOTS;
                r_in = (i_in - 1) / SLOTS + 1;
                if (s_in != 5)      ex = 4 * r_in;
                else if (r_in <= 2) ex = 4 * r_in;
                else if (r_in <= 5) ex = 8;
                else if (r_in == 6) ex = 0;
                else                ex = 4;
                chk($sformatf("stop_rst_slot%0d_rev%0d", s_in, r_in), int'(phase_a), ex);
            end
        end
        clk_en = 1'b0;
        stop = 1'b0;
        prst = 1'b0;

        // Random clk_en, then asynchronous reset in the middle of a revolution.
        do_reset();
        set_in(tab[0]);
        for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_enable();
            end else begin
                clk_en = 1'b0;
                @(posedge clk);
                #1;
                chk_ctl();
            end
            clk_en = 1'($urandom_range(0, 1));
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrun_reset_a", pack_a(), 0);
        chk("midrun_reset_b", pack_b(), 0);
        @(posedge clk);
        #3;
        clk_en = 1'b0;
        rst = 1'b1;
        en_cnt = 0;
        v = tab[0];
        v.revs = 1;
        v.exp_a = 4;
        v.exp_b = 4;
        run_vec(v, 10, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
